// File: rtl/st2bus.sv
`timescale 1ns/1ps
// st2bus: packs decoder Avalon-ST symbols into wide bus words for the memory
// writer. A word is assembled in an accumulator (ACC) and then moved into an
// output holding register (OUT). The holding register drives the bus and stays
// stable until the writer accepts the word. The low bits of each word carry a
// sideband header: sof, eof, err, nsym and word_idx.
module st2bus #(
   parameter int BUS            = 534,
   parameter int ST_PER_BUS     = 512,
   parameter int NUM_ST_PER_BUS = 42,
   parameter int ST             = 12,
   parameter int MAX_ST_PER_PKT = 1028
) (
   input  logic            clk_st,
   input  logic            rst_n,
   input  logic [ST-1:0]   st_data,
   input  logic            st_valid,
   input  logic            st_sop,
   input  logic            st_eop,
   input  logic            st_error,
   output logic            st_ready,
   output logic [BUS-1:0]  bus_data,
   output logic            bus_en,
   input  logic            bus_ready,
   output logic            pkt_done,
   output logic            err_drop
);

   localparam int HDR_W = BUS - ST_PER_BUS;
   localparam int ACC_W = NUM_ST_PER_BUS * ST;
   localparam int CNT_W = 6;
   localparam int SYM_W = 14;
   localparam int IDX_W = 7;

   typedef enum logic {S_IDLE = 1'b0, S_PKT = 1'b1} state_t;

   // Accumulator and packet tracking state
   state_t              r_state;
   logic [CNT_W-1:0]    r_acc_cnt;
   logic                r_acc_full;
   logic                r_acc_sof;
   logic                r_acc_eof;
   logic                r_acc_err;
   logic [SYM_W-1:0]    r_sym_cnt;
   logic                r_st_ready;
   logic                r_err_drop;

   // Output holding register state
   logic [BUS-1:0]      r_bus_data;
   logic                r_bus_en;
   logic                r_pkt_done;
   logic [IDX_W-1:0]    r_word_idx;

   logic                w_accept;
   logic                w_move;
   logic                w_xfer;
   logic                w_write;
   logic                w_drop;
   logic                w_close;
   logic                w_close_eof;
   logic                w_close_err;
   logic                w_acc_full_next;
   logic [CNT_W-1:0]    w_slot;
   logic [CNT_W-1:0]    w_cnt_inc;
   logic [SYM_W-1:0]    w_sym_inc;
   logic [IDX_W-1:0]    w_idx_use;
   logic [HDR_W-1:0]    w_header;
   logic [ST_PER_BUS-1:0] w_payload;

   assign w_accept  = st_valid && r_st_ready;
   // OUT is free when empty, or when its word transfers in this same cycle.
   assign w_move    = r_acc_full && (!r_bus_en || bus_ready);
   assign w_xfer    = r_bus_en && bus_ready;
   // A packet always opens at slot 0, whatever the counter says.
   assign w_slot    = (r_state == S_IDLE) ? '0 : r_acc_cnt;
   assign w_cnt_inc = w_slot + CNT_W'(1);
   assign w_sym_inc = r_sym_cnt + SYM_W'(1);
   // The first word of a packet restarts the index at zero.
   assign w_idx_use = r_acc_sof ? '0 : r_word_idx;
   assign w_acc_full_next = (r_acc_full && !w_move) || w_close;

   // Decode what the accepted beat does to the accumulator this cycle.
   always_comb begin
      w_write     = 1'b0;
      w_drop      = 1'b0;
      w_close     = 1'b0;
      w_close_eof = 1'b0;
      w_close_err = 1'b0;
      if (w_accept) begin
         if (r_state == S_IDLE) begin
            if (st_sop) begin
               w_write = 1'b1;
               if (st_eop) begin
                  w_close     = 1'b1;
                  w_close_eof = 1'b1;
                  w_close_err = st_error;
               end
            end else begin
               w_drop = 1'b1;
            end
         end else begin
            if (st_sop) begin
               // A new sop inside a packet: abort the current packet, drop the beat.
               w_drop      = 1'b1;
               w_close     = 1'b1;
               w_close_eof = 1'b1;
               w_close_err = 1'b1;
            end else begin
               w_write = 1'b1;
               if (st_eop) begin
                  w_close     = 1'b1;
                  w_close_eof = 1'b1;
                  w_close_err = st_error;
               end else if (w_sym_inc == SYM_W'(MAX_ST_PER_PKT)) begin
                  w_close     = 1'b1;
                  w_close_eof = 1'b1;
                  w_close_err = 1'b1;
               end else if (w_cnt_inc == CNT_W'(NUM_ST_PER_BUS)) begin
                  w_close = 1'b1;
               end
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_ST_PER_BUS; gi++) begin : g_slot
         logic [ST-1:0] r_sym;
         // Each slot captures its symbol once per word and clears when the word moves to OUT.
         always_ff @(posedge clk_st or negedge rst_n) begin
            if (!rst_n) begin
               r_sym <= '0;
            end else if (w_move) begin
               r_sym <= '0;
            end else if (w_write && (w_slot == CNT_W'(gi))) begin
               r_sym <= st_data;
            end
         end
         assign w_payload[gi*ST +: ST] = r_sym;
      end
      if (ST_PER_BUS > ACC_W) begin : g_pad
         assign w_payload[ST_PER_BUS-1:ACC_W] = '0;
      end
   endgenerate

   // Assemble the sideband header for the word sitting in ACC.
   always_comb begin
      w_header       = '0;
      w_header[0]    = r_acc_sof;
      w_header[1]    = r_acc_eof;
      w_header[2]    = r_acc_err;
      w_header[8:3]  = r_acc_cnt;
      w_header[15:9] = w_idx_use;
   end

   // Packet FSM, accumulator bookkeeping and the registered ready/drop outputs.
   always_ff @(posedge clk_st or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_acc_cnt  <= '0;
         r_acc_full <= 1'b0;
         r_acc_sof  <= 1'b0;
         r_acc_eof  <= 1'b0;
         r_acc_err  <= 1'b0;
         r_sym_cnt  <= '0;
         r_st_ready <= 1'b0;
         r_err_drop <= 1'b0;
      end else begin
         // Ready looks one cycle ahead so a closing word costs exactly one bubble.
         r_st_ready <= !w_acc_full_next;
         r_acc_full <= w_acc_full_next;
         r_err_drop <= w_drop;
         if (w_move) begin
            r_acc_cnt <= '0;
            r_acc_sof <= 1'b0;
            r_acc_eof <= 1'b0;
            r_acc_err <= 1'b0;
         end
         if (w_write) begin
            r_acc_cnt <= w_cnt_inc;
         end
         if (w_close) begin
            r_acc_eof <= w_close_eof;
            r_acc_err <= w_close_err;
         end
         if (w_accept) begin
            case (r_state)
               S_IDLE: begin
                  if (st_sop) begin
                     r_acc_sof <= 1'b1;
                     r_sym_cnt <= SYM_W'(1);
                     if (!st_eop) begin
                        r_state <= S_PKT;
                     end
                  end
               end
               S_PKT: begin
                  if (st_sop) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_sym_cnt <= w_sym_inc;
                     if (w_close_eof) begin
                        r_state <= S_IDLE;
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // Output holding register: load on move, hold while stalled, done pulse after eof transfer.
   always_ff @(posedge clk_st or negedge rst_n) begin
      if (!rst_n) begin
         r_bus_data <= '0;
         r_bus_en   <= 1'b0;
         r_pkt_done <= 1'b0;
         r_word_idx <= '0;
      end else begin
         r_pkt_done <= w_xfer && r_bus_data[1];
         if (w_move) begin
            r_bus_data <= {w_payload, w_header};
            r_bus_en   <= 1'b1;
            r_word_idx <= w_idx_use + IDX_W'(1);
         end else if (w_xfer) begin
            r_bus_en <= 1'b0;
         end
      end
   end

   assign st_ready = r_st_ready;
   assign bus_data = r_bus_data;
   assign bus_en   = r_bus_en;
   assign pkt_done = r_pkt_done;
   assign err_drop = r_err_drop;

endmodule

// File: tb/tb_st2bus.sv
`timescale 1ns/1ps
// Bench for st2bus: randomized symbol streams checked word-by-word against a
// packet-level reference model, plus directed packet-boundary scenarios.
module tb_st2bus;

   localparam int BUS  = 534;
   localparam int SPB  = 512;
   localparam int NUM  = 42;
   localparam int ST   = 12;
   localparam int MAXS = 1028;
   localparam int HW   = BUS - SPB;

   typedef logic [BUS-1:0] word_t;

   logic          clk_st = 1'b0;
   logic          rst_n = 1'b0;
   logic [ST-1:0] st_data = '0;
   logic          st_valid = 1'b0;
   logic          st_sop = 1'b0;
   logic          st_eop = 1'b0;
   logic          st_error = 1'b0;
   logic          st_ready;
   logic [BUS-1:0] bus_data;
   logic          bus_en;
   logic          bus_ready = 1'b0;
   logic          pkt_done;
   logic          err_drop;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit abort = 1'b0;
   int br_mode = 0;   // 0: always ready, 1: random, 2: stalled

   st2bus dut (
      .clk_st(clk_st), .rst_n(rst_n),
      .st_data(st_data), .st_valid(st_valid), .st_sop(st_sop),
      .st_eop(st_eop), .st_error(st_error), .st_ready(st_ready),
      .bus_data(bus_data), .bus_en(bus_en), .bus_ready(bus_ready),
      .pkt_done(pkt_done), .err_drop(err_drop)
   );

   always #5 clk_st = ~clk_st;
   always @(posedge clk_st) cyc++;

   // Memory-writer side: readiness pattern chosen by the running scenario.
   always @(posedge clk_st) begin
      #1;
      case (br_mode)
         0:       bus_ready = 1'b1;
         1:       bus_ready = ($urandom_range(0, 3) != 0);
         default: bus_ready = 1'b0;
      endcase
   end

   // Observed transfers and pulses.
   word_t obs_q[$];
   int drop_obs = 0;
   int done_obs = 0;
   always @(negedge clk_st) begin
      if (rst_n) begin
         if (bus_en && bus_ready) obs_q.push_back(bus_data);
         if (err_drop) drop_obs++;
         if (pkt_done) done_obs++;
      end
   end

   // ---------------- packet-level reference model ----------------
   word_t exp_q[$];
   logic [ST-1:0] m_syms[$];
   bit m_in_pkt;
   bit m_sof;
   int m_symcnt;
   int m_widx;
   int m_drops;
   int m_eofs;

   function automatic void m_close(bit eof, bit err);
      word_t w;
      w = '0;
      w[0] = m_sof;
      w[1] = eof;
      w[2] = err;
      w[8:3] = 6'(m_syms.size());
      w[15:9] = 7'(m_widx);
      foreach (m_syms[k]) w[HW + k*ST +: ST] = m_syms[k];
      exp_q.push_back(w);
      m_widx++;
      m_sof = 1'b0;
      m_syms.delete();
      if (eof) begin
         m_eofs++;
         m_in_pkt = 1'b0;
      end
   endfunction

   function automatic void m_beat(logic [ST-1:0] d, bit sop, bit eop, bit err);
      if (!m_in_pkt) begin
         if (sop) begin
            m_syms.delete();
            m_syms.push_back(d);
            m_symcnt = 1;
            m_sof = 1'b1;
            m_widx = 0;
            m_in_pkt = 1'b1;
            if (eop) m_close(1'b1, err);
         end else begin
            m_drops++;
         end
      end else if (sop) begin
         m_drops++;
         m_close(1'b1, 1'b1);
      end else begin
         m_syms.push_back(d);
         m_symcnt++;
         if (eop) m_close(1'b1, err);
         else if (m_symcnt == MAXS) m_close(1'b1, 1'b1);
         else if (m_syms.size() == NUM) m_close(1'b0, 1'b0);
      end
   endfunction

   function automatic void m_clear();
      exp_q.delete();
      m_syms.delete();
      m_in_pkt = 1'b0;
      m_sof = 1'b0;
      m_symcnt = 0;
      m_widx = 0;
      m_drops = 0;
      m_eofs = 0;
      obs_q.delete();
      drop_obs = 0;
      done_obs = 0;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic send_beat(input logic [ST-1:0] d, input bit sop, input bit eop, input bit err);
      int n;
      n = 0;
      if (abort) return;
      st_data = d; st_sop = sop; st_eop = eop; st_error = err; st_valid = 1'b1;
      forever begin
         @(negedge clk_st);
         if (st_ready) break;
         n++;
         if (n > 2000) begin
            checks++; failures++;
            $display("FAIL send_timeout st_ready stuck at %b for %0d cycles", st_ready, n);
            abort = 1'b1;
            st_valid = 1'b0;
            return;
         end
      end
      @(posedge clk_st);
      #1;
      st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; st_error = 1'b0;
      m_beat(d, sop, eop, err);
   endtask

   task automatic gap(input int max_cycles);
      repeat ($urandom_range(0, max_cycles)) begin
         @(posedge clk_st);
         #1;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((obs_q.size() < exp_q.size() || bus_en) && n < 5000) begin
         @(posedge clk_st);
         n++;
      end
      repeat (3) @(posedge clk_st);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk_st);
      #1;
      checks++;
      if (st_ready !== 1'b0 || bus_en !== 1'b0 || bus_data !== '0 || pkt_done !== 1'b0 || err_drop !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs got rdy=%b en=%b done=%b drop=%b data_nonzero=%b exp all 0",
                  st_ready, bus_en, pkt_done, err_drop, (bus_data !== '0));
      end
      rst_n = 1'b1;
      @(negedge clk_st);
      checks++;
      if (st_ready !== 1'b0) begin
         failures++; $display("FAIL reset_first_ready got=%b exp=0", st_ready);
      end
      @(posedge clk_st);
      #1;
      checks++;
      if (st_ready !== 1'b1) begin
         failures++; $display("FAIL reset_ready_rise got=%b exp=1", st_ready);
      end
   endtask

   task automatic test_latency();
      int c0, c1;
      m_clear();
      br_mode = 0;
      c0 = 0;
      for (int k = 0; k < NUM; k++) begin
         send_beat(ST'($urandom), k == 0, k == NUM - 1, 1'b0);
         if (k == 0) c0 = cyc;
      end
      c1 = cyc;
      checks++;
      if (c1 - c0 != NUM - 1) begin
         failures++; $display("FAIL lat_b2b_cycles got=%0d exp=%0d", c1 - c0, NUM - 1);
      end
      @(negedge clk_st);
      checks++;
      if (st_ready !== 1'b0 || bus_en !== 1'b0) begin
         failures++; $display("FAIL lat_bubble got rdy=%b en=%b exp rdy=0 en=0", st_ready, bus_en);
      end
      @(negedge clk_st);
      checks++;
      if (bus_en !== 1'b1) begin
         failures++; $display("FAIL lat_bus_en got=%b exp=1", bus_en);
      end
      drain();
      checks++;
      if (obs_q.size() != 1) begin
         failures++; $display("FAIL lat_count got=%0d exp=1", obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++; $display("FAIL lat_word[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if (done_obs != 1) begin
         failures++; $display("FAIL lat_pkt_done got=%0d exp=1", done_obs);
      end
   endtask

   task automatic test_long_packet();
      int c0, c1, bad;
      word_t w;
      m_clear();
      br_mode = 0;
      c0 = 0;
      for (int k = 0; k < MAXS; k++) begin
         send_beat(ST'(k), k == 0, k == MAXS - 1, 1'b0);
         if (k == 0) c0 = cyc;
      end
      c1 = cyc;
      drain();
      checks++;
      if (c1 - c0 != 1051) begin
         failures++; $display("FAIL long_throughput got=%0d exp=1051", c1 - c0);
      end
      checks++;
      if (obs_q.size() != 25) begin
         failures++; $display("FAIL long_count got=%0d exp=25", obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++; $display("FAIL long_word[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
         end
      end
      if (obs_q.size() >= 25) begin
         w = obs_q[24];
         checks++;
         if (w[8:3] !== 6'd20 || w[1] !== 1'b1 || w[15:9] !== 7'd24 || w[2] !== 1'b0) begin
            failures++;
            $display("FAIL long_last_hdr got nsym=%0d eof=%b idx=%0d err=%b exp 20/1/24/0", w[8:3], w[1], w[15:9], w[2]);
         end
         bad = 0;
         for (int k = 0; k < MAXS; k++) begin
            w = obs_q[k / NUM];
            if (w[HW + (k % NUM)*ST +: ST] !== ST'(k)) bad++;
         end
         checks++;
         if (bad != 0) begin
            failures++; $display("FAIL long_placement got bad_slots=%0d exp=0", bad);
         end
      end
      checks++;
      if (done_obs != 1 || drop_obs != 0) begin
         failures++; $display("FAIL long_pulses got done=%0d drop=%0d exp 1/0", done_obs, drop_obs);
      end
   endtask

   task automatic test_sop_eop_single();
      logic [ST-1:0] d[2];
      word_t w;
      m_clear();
      br_mode = 0;
      for (int e = 0; e < 2; e++) begin
         d[e] = ST'($urandom_range(1, 4095));
         send_beat(d[e], 1'b1, 1'b1, e[0]);
         gap(3);
      end
      drain();
      checks++;
      if (obs_q.size() != 2) begin
         failures++; $display("FAIL single_count got=%0d exp=2", obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < 2; i++) begin
         w = obs_q[i];
         checks++;
         if (w[8:0] !== {6'd1, i[0], 2'b11} || w[15:9] !== 7'd0 || w[HW +: ST] !== d[i] || w[BUS-1:HW+ST] !== '0) begin
            failures++;
            $display("FAIL single_word[%0d] got hdr=%h slot0=%h exp hdr=%h slot0=%h", i, w[15:0], w[HW +: ST],
                     {7'd0, 6'd1, i[0], 2'b11}, d[i]);
         end
      end
      checks++;
      if (done_obs != 2) begin
         failures++; $display("FAIL single_pkt_done got=%0d exp=2", done_obs);
      end
   endtask

   task automatic test_stall();
      m_clear();
      br_mode = 0;
      fork
         begin
            for (int k = 0; k < 300; k++) send_beat(ST'($urandom), k == 0, k == 299, 1'($urandom));
         end
         begin
            int n;
            int bad;
            word_t d0;
            n = 0;
            while (!bus_en && n < 500) begin @(negedge clk_st); n++; end
            br_mode = 2;
            @(posedge clk_st);
            #2;
            n = 0;
            while (!bus_en && n < 500) begin @(negedge clk_st); n++; end
            d0 = bus_data;
            bad = 0;
            repeat (100) begin
               @(negedge clk_st);
               if (bus_en !== 1'b1 || bus_data !== d0) bad++;
            end
            checks++;
            if (bad != 0) begin
               failures++; $display("FAIL stall_hold got unstable_cycles=%0d exp=0", bad);
            end
            checks++;
            if (st_ready !== 1'b0) begin
               failures++; $display("FAIL stall_ready got=%b exp=0", st_ready);
            end
            br_mode = 1;
         end
      join
      drain();
      br_mode = 0;
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++; $display("FAIL stall_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++; $display("FAIL stall_word[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if (done_obs != 1) begin
         failures++; $display("FAIL stall_pkt_done got=%0d exp=1", done_obs);
      end
   endtask

   task automatic test_sop_mid();
      word_t w;
      m_clear();
      br_mode = 0;
      for (int k = 0; k < 50; k++) send_beat(ST'($urandom), k == 0, 1'b0, 1'b0);
      send_beat(ST'($urandom), 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) send_beat(ST'($urandom), k == 0, k == 9, 1'b0);
      drain();
      checks++;
      if (obs_q.size() != 3) begin
         failures++; $display("FAIL sopmid_count got=%0d exp=3", obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++; $display("FAIL sopmid_word[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
         end
      end
      if (obs_q.size() >= 3) begin
         w = obs_q[1];
         checks++;
         if (w[8:3] !== 6'd8 || w[2:1] !== 2'b11) begin
            failures++; $display("FAIL sopmid_abort_hdr got nsym=%0d err_eof=%b exp 8/11", w[8:3], w[2:1]);
         end
         w = obs_q[2];
         checks++;
         if (w[0] !== 1'b1 || w[15:9] !== 7'd0 || w[8:3] !== 6'd10 || w[2:1] !== 2'b01) begin
            failures++; $display("FAIL sopmid_clean_hdr got hdr=%h exp=%h", w[15:0], 16'h0053);
         end
      end
      checks++;
      if (drop_obs != 1 || done_obs != 2) begin
         failures++; $display("FAIL sopmid_pulses got drop=%0d done=%0d exp 1/2", drop_obs, done_obs);
      end
   endtask

   task automatic test_no_eop();
      word_t w;
      m_clear();
      br_mode = 1;
      for (int k = 0; k < 1100; k++) send_beat(ST'($urandom), k == 0, 1'b0, 1'b0);
      drain();
      br_mode = 0;
      checks++;
      if (obs_q.size() != 25) begin
         failures++; $display("FAIL noeop_count got=%0d exp=25", obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++; $display("FAIL noeop_word[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
         end
      end
      if (obs_q.size() >= 25) begin
         w = obs_q[24];
         checks++;
         if (w[8:3] !== 6'd20 || w[2:1] !== 2'b11) begin
            failures++; $display("FAIL noeop_last_hdr got nsym=%0d err_eof=%b exp 20/11", w[8:3], w[2:1]);
         end
      end
      checks++;
      if (drop_obs != 72 || done_obs != 1) begin
         failures++; $display("FAIL noeop_pulses got drop=%0d done=%0d exp 72/1", drop_obs, done_obs);
      end
   endtask

   task automatic test_random();
      int len;
      m_clear();
      br_mode = 1;
      for (int p = 0; p < 10; p++) begin
         if ($urandom_range(0, 3) == 0) send_beat(ST'($urandom), 1'b0, 1'b0, 1'b0);
         len = $urandom_range(1, 130);
         for (int k = 0; k < len; k++) begin
            send_beat(ST'($urandom), k == 0, k == len - 1, 1'($urandom));
            if ($urandom_range(0, 7) == 0) gap(4);
         end
         gap(6);
      end
      drain();
      br_mode = 0;
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++; $display("FAIL rand_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++; $display("FAIL rand_word[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if (drop_obs != m_drops || done_obs != m_eofs) begin
         failures++; $display("FAIL rand_pulses got drop=%0d done=%0d exp %0d/%0d", drop_obs, done_obs, m_drops, m_eofs);
      end
   endtask

   task automatic test_reset_mid();
      word_t w;
      m_clear();
      br_mode = 0;
      for (int k = 0; k < 30; k++) send_beat(ST'($urandom), k == 0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (st_ready !== 1'b0 || bus_en !== 1'b0 || bus_data !== '0 || pkt_done !== 1'b0 || err_drop !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_outputs got rdy=%b en=%b done=%b drop=%b data_nonzero=%b exp all 0",
                  st_ready, bus_en, pkt_done, err_drop, (bus_data !== '0));
      end
      repeat (3) @(posedge clk_st);
      #1;
      rst_n = 1'b1;
      m_clear();
      for (int k = 0; k < NUM; k++) send_beat(ST'($urandom), k == 0, k == NUM - 1, 1'b0);
      drain();
      checks++;
      if (obs_q.size() != 1) begin
         failures++; $display("FAIL rstmid_count got=%0d exp=1", obs_q.size());
      end
      if (obs_q.size() >= 1) begin
         w = obs_q[0];
         checks++;
         if (w[1:0] !== 2'b11 || w[15:9] !== 7'd0 || w[8:3] !== 6'd42) begin
            failures++; $display("FAIL rstmid_hdr got hdr=%h exp sof=eof=1 idx=0 nsym=42", w[15:0]);
         end
         checks++;
         if (exp_q.size() < 1 || w !== exp_q[0]) begin
            failures++; $display("FAIL rstmid_word got=%h", w);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      m_clear();
      test_reset();
      test_latency();
      test_long_packet();
      test_sop_eop_single();
      test_stall();
      test_sop_mid();
      test_no_eop();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/st2bus.md
Name: st2bus

Overview:
- Packs the turbo decoder's Avalon-ST output symbols into wide parallel bus words for the memory writer, so that results can be written back to memory.
- Symbol lane layout is the inverse of the memory-to-ST input path: symbol k of a word is carried at bus_data[BUS-ST_PER_BUS + k*ST +: ST]. Unused upper payload bits are zero.
- The low BUS-ST_PER_BUS bits of each word carry a sideband header.
- Two-stage buffer: an accumulator (ACC) and an output holding register (OUT).

Parameters:
BUS, 534, output bus width
ST_PER_BUS, 512, payload bits per bus word
NUM_ST_PER_BUS, 42, symbols per bus word (must satisfy NUM_ST_PER_BUS*ST <= ST_PER_BUS)
ST, 12, symbol width
MAX_ST_PER_PKT, 1028, maximum symbols per packet before a forced close

Ports:
clk_st  in  1  single clock for the whole block
rst_n  in  1  asynchronous reset, active low
st_data  in  ST  decoder symbol
st_valid  in  1  symbol valid
st_sop  in  1  start of packet
st_eop  in  1  end of packet
st_error  in  1  decoder error, sampled on the eop beat
st_ready  out  1  registered ready to the decoder
bus_data  out  BUS  packed word plus header
bus_en  out  1  bus word valid
bus_ready  in  1  memory writer accepts the word
pkt_done  out  1  one-cycle pulse when an eof word transfers
err_drop  out  1  one-cycle pulse when an accepted beat is discarded

Behaviour:
- Reset (async, rst_n=0): st_ready=0, bus_en=0, bus_data=0, pkt_done=0, err_drop=0; FSM=IDLE; ACC empty; OUT empty; all counters 0.
- st_ready is 0 in the first cycle after reset release. From then on, st_ready = !acc_full, registered.
- st_ready never depends on st_valid or st_sop.
- A beat is accepted when st_valid && st_ready.
- Header (low bits of bus_data):
  - [0] sof: first word of the packet
  - [1] eof: last word of the packet
  - [2] err: error flag
  - [8:3] nsym: valid symbols in the word, 0..42
  - [15:9] word_idx: word index within the packet, 7-bit, wraps
  - [BUS-ST_PER_BUS-1:16] = 0
- Symbol slots at index >= nsym are zero.
- FSM states:
  - IDLE:
    - Accepted beat with sop: write the symbol to slot 0, cnt=1, sym_cnt=1, mark the word sof, go to PKT.
    - If the same beat also has eop, close the word immediately (nsym=1, sof=eof=1, err=st_error) and stay in IDLE.
    - Accepted beat without sop: discard it and pulse err_drop.
  - PKT:
    - Accepted non-sop beat: write to slot cnt and increment cnt and sym_cnt (14-bit).
    - Close the word when cnt reaches NUM_ST_PER_BUS, or on eop (eof=1, err=st_error, go to IDLE).
    - Close the word when sym_cnt reaches MAX_ST_PER_PKT without eop: eof=1, err=1, go to IDLE.
    - Accepted sop beat in PKT: discard the beat and pulse err_drop. Close the current word with eof=1, err=1, nsym=cnt (nsym=0 allowed) and go to IDLE.
- Closing a word sets acc_full.
- ACC to OUT move happens in any cycle where acc_full && (!bus_en || bus_ready). On the move: OUT is loaded, bus_en=1 the next cycle, ACC is cleared, and word_idx increments (word_idx is reset on sof).
- Latency: the last symbol of a word accepted in cycle t gives bus_en=1 in cycle t+2 when OUT is free.
  - This costs exactly one st_ready bubble (cycle t+1) per word.
  - Sustained throughput is 42 symbols per 43 cycles.
- bus_data and bus_en hold stable while bus_en && !bus_ready. The transfer occurs on bus_en && bus_ready. bus_en drops the next cycle unless a new move occurs in the same cycle.
- pkt_done pulses in the cycle after an eof word transfers.
- Buffering: when OUT is stalled and ACC fills, st_ready stays 0 until the move. No beat is ever lost or duplicated.
- Reset mid-packet: all state is discarded, and any partial word is not emitted.

Test Plan:
- 1028-symbol packet, values k=0..1027, bus_ready=1 -> exactly 25 words.
  - Words 0..23: nsym=42. Word 24: nsym=20, eof=1, word_idx=24.
  - Symbol k appears in word k/42, slot k%42.
  - pkt_done pulses once.
- Single beat with sop=eop=1 in IDLE -> one word: sof=eof=1, nsym=1, slot 0 = data, err=st_error.
- bus_ready=0 for 100 cycles during streaming -> bus_data is stable, st_ready=0 once ACC is full, and the full symbol sequence is intact after release.
- sop at symbol 50 of an open packet -> word 1 closes with nsym=8, eof=1, err=1; err_drop pulses; the next sop starts a clean packet.
- 1100 symbols with no eop -> word 24 has nsym=20, eof=1, err=1; the remaining 72 beats produce 72 err_drop pulses.
- rst_n asserted at symbol 30 -> all outputs are 0 immediately; a subsequent 42-symbol packet gives one word with sof=eof=1 and word_idx=0.
